mult_wb_unit: RTL and testbench

Result-side companion to the multiplier issue manager. It captures results leaving the last stage of the pipelined multipliers, selects the low or high 32 bits, and queues them in a small FIFO. It drains them into the register-file write port whenever the main integer pipeline leaves the port idle. It also tells issue logic when to stop launching multiplies, and forwards queued results to decode.

---
 rtl/mult_wb_unit_pkg.sv | 29 ++
 rtl/mult_wb_fifo.sv | 78 +++++++
 rtl/mult_wb_unit.sv | 117 +++++++++++
 tb/tb_mult_wb_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_wb_unit_pkg.sv
// Shared multiplier definitions: pipeline depth, result-type encodings and
// the queued write-back entry layout used by the multiplier result path.
package mult_wb_unit_pkg;

  localparam int MULT_PPL_STAGE = 4;

  localparam logic [1:0] MULT_LOW32   = 2'b00;
  localparam logic [1:0] MULT_HIGH_SS = 2'b01;
  localparam logic [1:0] MULT_HIGH_SU = 2'b10;
  localparam logic [1:0] MULT_HIGH_UU = 2'b11;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_entry_t;

  // Low-word products keep bits [31:0]; every high variant keeps [63:32].
  function automatic logic [31:0] select_result(input logic [1:0] res_type,
                                                input logic [63:0] res_p);
    logic [31:0] sel;
    case (res_type)
      MULT_LOW32:                               sel = res_p[31:0];
      MULT_HIGH_SS, MULT_HIGH_SU, MULT_HIGH_UU: sel = res_p[63:32];
      default:                                  sel = res_p[63:32];
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mult_wb_fifo.sv
// Small circular queue of pending multiply write-backs, exposing every slot
// with its valid bit and age so the top level can search it for forwarding.
module mult_wb_fifo
  import mult_wb_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  wb_entry_t                push_entry,
  output wb_entry_t                head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [DEPTH-1:0]         entry_valid,
  output wb_entry_t                entries [DEPTH],
  output logic [$clog2(DEPTH)-1:0] entry_age [DEPTH]
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t        mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign head        = mem[rd_ptr];
  assign entry_valid = valid_q;

  // When full, push and pop hit the same slot; the set must win over the clear.
  always_comb begin
    valid_d = valid_q;
    if (pop)
      valid_d[rd_ptr] = 1'b0;
    if (push)
      valid_d[wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= push_entry;
  end

  // Age is the distance from the head, so larger means younger.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i]   = mem[i];
      entry_age[i] = PW'(i) - rd_ptr;
    end
  end

endmodule

// File: rtl/mult_wb_unit.sv
// Multiply result write-back: queues finished products, drains them into the
// register file when the main pipeline leaves the port idle, and forwards them.
module mult_wb_unit
  import mult_wb_unit_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int STAGES = MULT_PPL_STAGE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              res_valid,
  input  logic [4:0]        res_rd_addr,
  input  logic [1:0]        res_type,
  input  logic [63:0]       res_p,
  input  logic [STAGES-1:0] inflight,
  input  logic              main_we,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic              issue_stall,
  input  logic [4:0]        q_addr_a,
  input  logic [4:0]        q_addr_b,
  output logic              hit_a,
  output logic              hit_b,
  output logic [31:0]       fwd_a,
  output logic [31:0]       fwd_b,
  output logic              ovf
);

  localparam int PW = $clog2(DEPTH);

  logic                   push_req;
  logic                   push;
  logic                   pop;
  wb_entry_t              push_entry;
  wb_entry_t              head;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   empty;
  logic [DEPTH-1:0]       entry_valid;
  wb_entry_t              entries [DEPTH];
  logic [PW-1:0]          entry_age [DEPTH];
  logic [31:0]            inflight_cnt;
  logic [4:0]             q_addr [2];
  logic                   hit [2];
  logic [31:0]            fwd [2];
  logic [PW-1:0]          best_age [2];

  // Writes to x0 are architecturally void, so they never take a slot.
  assign push_req        = res_valid && (res_rd_addr != 5'd0);
  assign pop             = !empty && !main_we;
  assign push            = push_req && (!full || pop);
  assign push_entry.addr = res_rd_addr;
  assign push_entry.data = select_result(res_type, res_p);

  assign rf_we    = pop;
  assign rf_waddr = head.addr;
  assign rf_wdata = head.data;

  mult_wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .pop         (pop),
    .push_entry  (push_entry),
    .head        (head),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .entry_valid (entry_valid),
    .entries     (entries),
    .entry_age   (entry_age)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf <= 1'b0;
    else if (push_req && full && !pop)
      ovf <= 1'b1;
  end

  // Reserve a slot for every multiply still in the pipeline.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < STAGES; i++)
      inflight_cnt = inflight_cnt + 32'(inflight[i]);
    issue_stall = (32'(count) + inflight_cnt) >= 32'(DEPTH);
  end

  assign q_addr[0] = q_addr_a;
  assign q_addr[1] = q_addr_b;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      hit[p]      = 1'b0;
      fwd[p]      = '0;
      best_age[p] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (entry_valid[i] && (entries[i].addr == q_addr[p]) && (q_addr[p] != 5'd0)) begin
          if (!hit[p] || (entry_age[i] >= best_age[p])) begin
            hit[p]      = 1'b1;
            fwd[p]      = entries[i].data;
            best_age[p] = entry_age[i];
          end
        end
      end
    end
  end

  assign hit_a = hit[0];
  assign hit_b = hit[1];
  assign fwd_a = fwd[0];
  assign fwd_b = fwd[1];

endmodule

// File: tb/tb_mult_wb_unit.sv
// Directed bench for mult_wb_unit: expected register-file writes go into a
// scoreboard queue that a negedge monitor pops whenever rf_we is seen.
module tb_mult_wb_unit;
  import mult_wb_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        res_valid;
  logic [4:0]  res_rd_addr;
  logic [1:0]  res_type;
  logic [63:0] res_p;
  logic [3:0]  inflight;
  logic        main_we;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        issue_stall;
  logic [4:0]  q_addr_a;
  logic [4:0]  q_addr_b;
  logic        hit_a;
  logic        hit_b;
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;
  logic [36:0] exp_q [$];

  mult_wb_unit #(
    .DEPTH  (4),
    .STAGES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .res_valid   (res_valid),
    .res_rd_addr (res_rd_addr),
    .res_type    (res_type),
    .res_p       (res_p),
    .inflight    (inflight),
    .main_we     (main_we),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .issue_stall (issue_stall),
    .q_addr_a    (q_addr_a),
    .q_addr_b    (q_addr_b),
    .hit_a       (hit_a),
    .hit_b       (hit_b),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .ovf         (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One result on res_*, held for a single clock; accepted ones are scored.
  task automatic apply_stimulus(input logic [4:0] rd, input logic [1:0] typ,
                                input logic [63:0] p, input logic [31:0] exp_data,
                                input bit accept);
    res_valid   = 1'b1;
    res_rd_addr = rd;
    res_type    = typ;
    res_p       = p;
    if (accept)
      exp_q.push_back({rd, exp_data});
    step();
    res_valid = 1'b0;
  endtask

  // Monitor: every observed write must match the oldest expected write.
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clk);
      if (!rst && rf_we) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_write", {27'd0, rf_waddr}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_output("wb_addr", {27'd0, rf_waddr}, {27'd0, e[36:32]});
          check_output("wb_data", rf_wdata, e[31:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; res_valid = 1'b0; res_rd_addr = '0; res_type = '0; res_p = '0;
    inflight = '0; main_we = 1'b0; q_addr_a = 5'd5; q_addr_b = 5'd0;
    repeat (2) step();

    check_output("rst_rf_we", {31'd0, rf_we}, 32'd0);
    check_output("rst_hit_a", {31'd0, hit_a}, 32'd0);
    check_output("rst_ovf", {31'd0, ovf}, 32'd0);
    check_output("rst_count", 32'(dut.u_fifo.count), 32'd0);
    check_output("rst_stall_0", {31'd0, issue_stall}, 32'd0);
    inflight = 4'b1111; #1;
    check_output("rst_stall_4", {31'd0, issue_stall}, 32'd1);
    inflight = 4'b0111; #1;
    check_output("rst_stall_3", {31'd0, issue_stall}, 32'd0);
    inflight = '0;
    rst = 1'b0;
    step();

    // Single result plus the other data-select variants.
    apply_stimulus(5'd5, 2'b01, 64'h12345678_9ABCDEF0, 32'h12345678, 1'b1);
    check_output("single_count", 32'(dut.u_fifo.count), 32'd1);
    check_output("single_rf_we", {31'd0, rf_we}, 32'd1);
    apply_stimulus(5'd6, 2'b00, 64'h12345678_9ABCDEF0, 32'h9ABCDEF0, 1'b1);
    apply_stimulus(5'd8, 2'b11, 64'hCAFEF00D_0BADBEEF, 32'hCAFEF00D, 1'b1);
    step();
    check_output("single_drained", 32'(dut.u_fifo.count), 32'd0);

    // x0 destination is discarded.
    apply_stimulus(5'd0, 2'b00, 64'h0000_0000_DEAD_BEEF, 32'd0, 1'b0);
    check_output("x0_count", 32'(dut.u_fifo.count), 32'd0);
    check_output("x0_rf_we", {31'd0, rf_we}, 32'd0);

    // Fill while main pipeline owns the port, then overflow.
    main_we = 1'b1;
    for (int i = 1; i <= 4; i++)
      apply_stimulus(5'(i), 2'b00, {32'd0, 32'hA000_0000 + 32'(i)}, 32'hA000_0000 + 32'(i), 1'b1);
    check_output("fill_count", 32'(dut.u_fifo.count), 32'd4);
    check_output("fill_stall", {31'd0, issue_stall}, 32'd1);
    check_output("fill_ovf", {31'd0, ovf}, 32'd0);
    apply_stimulus(5'd10, 2'b00, 64'h0000_0000_0000_00EE, 32'd0, 1'b0);
    check_output("ovf_set", {31'd0, ovf}, 32'd1);
    check_output("ovf_count", 32'(dut.u_fifo.count), 32'd4);
    main_we = 1'b0;
    repeat (4) step();
    check_output("drain4_count", 32'(dut.u_fifo.count), 32'd0);
    check_output("ovf_sticky", {31'd0, ovf}, 32'd1);
    #2 rst = 1'b1;
    #1 check_output("ovf_cleared", {31'd0, ovf}, 32'd0);
    rst = 1'b0;
    step();

    // Push into a full queue in the same cycle as a pop.
    main_we = 1'b1;
    for (int i = 1; i <= 4; i++)
      apply_stimulus(5'(i), 2'b00, {32'd0, 32'hB000_0000 + 32'(i)}, 32'hB000_0000 + 32'(i), 1'b1);
    main_we = 1'b0;
    apply_stimulus(5'd9, 2'b00, 64'h0000_0000_0000_9999, 32'h0000_9999, 1'b1);
    check_output("fullpop_ovf", {31'd0, ovf}, 32'd0);
    check_output("fullpop_count", 32'(dut.u_fifo.count), 32'd4);
    repeat (4) step();
    check_output("fullpop_drained", 32'(dut.u_fifo.count), 32'd0);

    // Forwarding: newest write to a register wins; x0 never hits.
    main_we     = 1'b1;
    q_addr_a    = 5'd7;
    res_valid   = 1'b1;
    res_rd_addr = 5'd7;
    res_type    = 2'b00;
    res_p       = 64'h0000_0000_0000_000A;
    #1 check_output("fwd_no_bypass", {31'd0, hit_a}, 32'd0);
    exp_q.push_back({5'd7, 32'h0000_000A});
    step();
    res_valid = 1'b0;
    check_output("fwd_first_hit", {31'd0, hit_a}, 32'd1);
    check_output("fwd_first_data", fwd_a, 32'h0000_000A);
    apply_stimulus(5'd3, 2'b00, 64'h0000_0000_0000_000C, 32'h0000_000C, 1'b1);
    apply_stimulus(5'd7, 2'b00, 64'h0000_0000_0000_000B, 32'h0000_000B, 1'b1);
    q_addr_b = 5'd0; #1;
    check_output("fwd_hit_a", {31'd0, hit_a}, 32'd1);
    check_output("fwd_data_a", fwd_a, 32'h0000_000B);
    check_output("fwd_x0_hit_b", {31'd0, hit_b}, 32'd0);
    q_addr_b = 5'd3; #1;
    check_output("fwd_hit_b", {31'd0, hit_b}, 32'd1);
    check_output("fwd_data_b", fwd_b, 32'h0000_000C);
    q_addr_a = 5'd12; #1;
    check_output("fwd_miss_a", {31'd0, hit_a}, 32'd0);
    q_addr_a = 5'd7;
    main_we  = 1'b0;
    step();
    check_output("fwd_after_pop_data", fwd_a, 32'h0000_000B);
    repeat (2) step();
    check_output("fwd_drained_hit", {31'd0, hit_a}, 32'd0);

    // Credit stall and asynchronous reset while results are pending.
    main_we = 1'b1;
    apply_stimulus(5'd11, 2'b01, 64'h0000_0011_0000_0000, 32'h0000_0011, 1'b1);
    apply_stimulus(5'd12, 2'b01, 64'h0000_0012_0000_0000, 32'h0000_0012, 1'b1);
    inflight = 4'b0011; #1;
    check_output("stall_2_2", {31'd0, issue_stall}, 32'd1);
    inflight = 4'b0001; #1;
    check_output("stall_2_1", {31'd0, issue_stall}, 32'd0);
    inflight = '0;
    apply_stimulus(5'd13, 2'b01, 64'h0000_0013_0000_0000, 32'h0000_0013, 1'b1);
    apply_stimulus(5'd14, 2'b01, 64'h0000_0014_0000_0000, 32'h0000_0014, 1'b1);
    apply_stimulus(5'd15, 2'b01, 64'h0000_0015_0000_0000, 32'd0, 1'b0);
    check_output("pre_rst_ovf", {31'd0, ovf}, 32'd1);
    #2;
    rst     = 1'b1;
    main_we = 1'b0;
    exp_q.delete();
    #1;
    check_output("arst_count", 32'(dut.u_fifo.count), 32'd0);
    check_output("arst_ovf", {31'd0, ovf}, 32'd0);
    check_output("arst_rf_we", {31'd0, rf_we}, 32'd0);
    check_output("arst_stall", {31'd0, issue_stall}, 32'd0);
    step();
    rst = 1'b0;
    repeat (3) step();
    check_output("post_rst_rf_we", {31'd0, rf_we}, 32'd0);
    check_output("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
